frame_timer: RTL
================

# frame_timer

Multi-channel programmable frame timer for the SoC's AHB-lite peripheral space. Each channel divides `clk` by a software-set period, produces a tick, counts ticks into a wrapping frame counter, and raises a maskable, sticky interrupt. It replaces the fixed-rate 30/60 fps timer: rates, frame wrap and one-shot mode are programmed at run time.

## Interface

**Parameters**
- `N_CH`, 2: number of independent channels, 1..8.
- `CNT_W`, 24: period counter width.
- `FRM_W`, 8: frame counter width.
- `DEF_PERIOD`, 1666666: reset value of every PERIOD register (30 fps at 50 MHz).
- `DEF_FLIM`, 29: reset value of every frame-limit register.

**Ports**
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset; synchronous, active-low.
- `wr_en`, in, 1: register write strobe, one cycle.
- `addr`, in, `$clog2(N_CH)+2`: word address. `addr[1:0]` selects the register; upper bits select the channel.
- `wdata`, in, 32: write data.
- `rdata`, out, 32: read data, combinational from `addr`.
- `tick`, out, `N_CH`: per-channel period-wrap pulse.
- `irq`, out, `N_CH`: per-channel interrupt level.
- `irq_any`, out, 1: OR of `irq`.

## Operation

**Register map (per channel)**
- Reg 0, CTRL:
  - bit0 `en`, reset 1.
  - bit1 `irq_en`, reset 1.
  - bit2 `oneshot`, reset 0.
  - Other bits read 0.
- Reg 1, PERIOD: `CNT_W` bits.
  - The channel wraps after PERIOD+1 cycles.
  - Writing PERIOD also clears `count` to 0.
- Reg 2, FRAMES:
  - Write sets `flim` (`FRM_W` bits).
  - Read returns `{flim` in bits [23:16], `frame` in bits [`FRM_W`-1:0]}`.
  - Writing FRAMES clears `frame` to 0.
- Reg 3, STATUS:
  - bit0 `pending`. Write 1 clears it; write 0 has no effect.
  - Read returns `pending`.
- Writes to a channel index ≥ `N_CH` are ignored. Reads from such an index return 0.

**Per-channel datapath**
- `tick[c] = en & (count >= period)`. This is combinational from the registered state.
- Each clock with `en`=1:
  - If `tick`: `count` ← 0.
  - Otherwise: `count` ← `count`+1.
- `en`=0 freezes `count` and `frame`. They are not cleared.
- On `tick`:
  - If `frame == flim`: `frame` ← 0.
  - Otherwise: `frame` ← `frame`+1.
  - `frame` never changes without a tick.
- On `tick`, `pending` ← 1.
- On `tick` with `oneshot`=1, `en` ← 0 on the same edge.
- `irq[c] = pending & irq_en`. `irq_any = |irq`.

**Boundary rules**
- PERIOD=0: `tick` is high every enabled cycle.
- If PERIOD is lowered below the current `count` by a write, the write already clears `count`. The `>=` compare is a safety net only.
- `flim`=0: `frame` stays 0; `pending` still sets each tick.
- `frame` wraps at `flim`, not at 2^`FRM_W`. If `flim` is written below the current `frame`, the write already clears `frame`.
- Simultaneous tick and STATUS W1C on the same channel: set wins, so `pending` stays 1.
- Simultaneous tick and PERIOD write: the write wins, `count` ← 0. `frame` and `pending` still update from the tick.
- Simultaneous tick and CTRL write: the written `en` value wins over the one-shot clear.
- Simultaneous tick and FRAMES write: `frame` ← 0. The tick's increment is dropped.

## Timing

- **Reset** (`rst_n`=0 at an edge). Values after that edge:
  - `count`=0, `frame`=0, `pending`=0.
  - `period`=`DEF_PERIOD`, `flim`=`DEF_FLIM`.
  - `en`=1, `irq_en`=1, `oneshot`=0.
  - Outputs: `tick`=0, `irq`=0, `irq_any`=0.
- Reset mid-count aborts the count immediately; there is no carry-over.
- First tick after reset is at cycle `DEF_PERIOD` after the reset is released, counting the first enabled cycle as 0.
- Ticks are periodic at PERIOD+1 cycles, with `tick` high for exactly 1 cycle.
- `pending` and `irq` rise on the edge that ends the tick cycle: 1 cycle after `tick`.
- Register writes take effect on the `wr_en` edge. A read in the following cycle returns the new value.
- `rdata` has 0 latency from `addr`.
- `count` and `frame` are independent per channel. Channels share no state except the bus.

## Test plan

1. **Reset defaults.** Release reset, hold for 1,666,667 cycles. Expect:
   - `tick[0]` pulses exactly at cycle 1,666,666.
   - `irq[0]` is high the next cycle.
   - The FRAMES read reports `frame`=1, `flim`=29.
2. **Frame wrap and freeze.** On ch1, write PERIOD=3 and FRAMES=2. Expect:
   - A tick every 4 cycles.
   - `frame` sequence 0,1,2,0,1.
   - After writing CTRL `en`=0, `count` and `frame` hold for 20 cycles.
   - Re-enabling resumes from the held values.
3. **One-shot.** Write CTRL=0b101 and PERIOD=5. Expect:
   - A single tick 5 cycles after the write.
   - `en` reads 0 afterwards, with no further ticks for 50 cycles.
   - `pending`=1, and `irq`=0 because `irq_en`=0.
4. **W1C collision.** Write STATUS=1 in the same cycle as a tick. Expect:
   - `pending` still 1.
   - A W1C on a non-tick cycle clears it.
   - STATUS write 0 leaves it unchanged.
5. **PERIOD=0 and shrink.**
   - With PERIOD=0, expect a tick every cycle and `frame` incrementing each cycle.
   - With PERIOD=100, at `count`=60 write PERIOD=10. Expect `count` to restart at 0 and the next tick 10 cycles later.
6. **Reset mid-operation and channel isolation.**
   - Assert `rst_n`=0 for 1 cycle mid-run. Expect all registers back to defaults on that edge.
   - Configure ch0 and ch1 with different periods. Expect `irq_any` to follow the OR of both, and an out-of-range address to read 0.

Source files
------------

// File: rtl/frame_timer.sv
// Multi-channel programmable frame timer.
// Each channel divides clk by PERIOD+1 and pulses tick. It counts ticks into a frame
// counter that wraps at flim, and latches a sticky pending flag that drives a maskable
// interrupt. The four registers per channel sit on a small word-addressed write/read bus.

module frame_timer #(
   parameter int unsigned N_CH       = 2,
   parameter int unsigned CNT_W      = 24,
   parameter int unsigned FRM_W      = 8,
   parameter int unsigned DEF_PERIOD = 1666666,
   parameter int unsigned DEF_FLIM   = 29,
   localparam int unsigned AW        = $clog2(N_CH) + 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wr_en,
   input  logic [AW-1:0]   addr,
   input  logic [31:0]     wdata,
   output logic [31:0]     rdata,
   output logic [N_CH-1:0] tick,
   output logic [N_CH-1:0] irq,
   output logic            irq_any
);

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PERIOD = 2'd1;
   localparam logic [1:0] REG_FRAMES = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   // Decoded bus fields; the channel index is widened so out-of-range indices stay visible
   logic [31:0]     sel_ch;
   logic [1:0]      sel_reg;
   logic            sel_valid;

   logic [N_CH-1:0] wr_ctrl;
   logic [N_CH-1:0] wr_period;
   logic [N_CH-1:0] wr_frames;
   logic [N_CH-1:0] wr_status;

   // Read view of every channel's register file, muxed onto rdata below
   logic [31:0]     reg_rd [N_CH][4];

   // Split the word address into channel index and register select
   always_comb begin
      sel_ch    = 32'(addr >> 2);
      sel_reg   = addr[1:0];
      sel_valid = (sel_ch < N_CH);
   end

   // Per-channel write strobes; writes to a nonexistent channel decode to nothing
   always_comb begin
      wr_ctrl   = '0;
      wr_period = '0;
      wr_frames = '0;
      wr_status = '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
         if (wr_en && sel_valid && (sel_ch == c)) begin
            wr_ctrl[c]   = (sel_reg == REG_CTRL);
            wr_period[c] = (sel_reg == REG_PERIOD);
            wr_frames[c] = (sel_reg == REG_FRAMES);
            wr_status[c] = (sel_reg == REG_STATUS);
         end
      end
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      logic             en_q;
      logic             irq_en_q;
      logic             oneshot_q;
      logic             pending_q;
      logic [CNT_W-1:0] count_q;
      logic [CNT_W-1:0] period_q;
      logic [FRM_W-1:0] frame_q;
      logic [FRM_W-1:0] flim_q;
      logic             ch_tick;

      // >= rather than == so a count left above a lowered period still wraps
      assign ch_tick = en_q & (count_q >= period_q);
      assign tick[c] = ch_tick;
      assign irq[c]  = pending_q & irq_en_q;

      assign reg_rd[c][0] = {29'd0, oneshot_q, irq_en_q, en_q};
      assign reg_rd[c][1] = 32'(period_q);
      assign reg_rd[c][2] = (32'(flim_q) << 16) | 32'(frame_q);
      assign reg_rd[c][3] = {31'd0, pending_q};

      // Channel state: register writes take priority over the tick-driven updates,
      // except pending, where a tick's set beats a same-cycle clear
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            en_q      <= 1'b1;
            irq_en_q  <= 1'b1;
            oneshot_q <= 1'b0;
            pending_q <= 1'b0;
            count_q   <= '0;
            period_q  <= CNT_W'(DEF_PERIOD);
            frame_q   <= '0;
            flim_q    <= FRM_W'(DEF_FLIM);
         end else begin
            if (wr_ctrl[c]) begin
               en_q      <= wdata[0];
               irq_en_q  <= wdata[1];
               oneshot_q <= wdata[2];
            end else if (ch_tick && oneshot_q) begin
               en_q <= 1'b0;
            end

            if (wr_period[c]) begin
               period_q <= wdata[CNT_W-1:0];
               count_q  <= '0;
            end else if (en_q) begin
               count_q <= ch_tick ? '0 : count_q + CNT_W'(1);
            end

            if (wr_frames[c]) begin
               flim_q  <= wdata[FRM_W-1:0];
               frame_q <= '0;
            end else if (ch_tick) begin
               frame_q <= (frame_q == flim_q) ? '0 : frame_q + FRM_W'(1);
            end

            if (ch_tick) begin
               pending_q <= 1'b1;
            end else if (wr_status[c] && wdata[0]) begin
               pending_q <= 1'b0;
            end
         end
      end
   end

   // Combinational read mux; nonexistent channels read as zero
   always_comb begin
      rdata = '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
         if (sel_valid && (sel_ch == c)) begin
            rdata = reg_rd[c][sel_reg];
         end
      end
   end

   assign irq_any = |irq;

endmodule
